// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller that conditions the front-panel buttons and issues the
// one-cycle cpu_clk_en strobe; define CLK_STEP_CTRL_DEBOUNCE_EN to build the debounce counters.
module clk_step_ctrl #(
    parameter int DIV_W      = 16,
    parameter int DEB_W      = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             cpu_hlt,
    input  logic [DIV_W-1:0] div,
    output logic             cpu_clk_en,
    output logic             running,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'b00,
        ST_RUNNING = 2'b01,
        ST_STEP    = 2'b10
    } state_e;

    if (DEB_CYCLES < 1 || DEB_CYCLES >= (1 << DEB_W)) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must lie in 1 .. 2**DEB_W-1");
    end

    // Button vectors: bit 0 is run/halt, bit 1 is single-step.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level;
    logic [1:0] level_prev_q;
    logic [1:0] press_q;
    logic       run_p;
    logic       step_p;

    assign raw = {btn_step, btn_run};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level;
            press_q      <= level & ~level_prev_q;
        end
    end

`ifdef CLK_STEP_CTRL_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;

    // A change is only accepted after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            deb_d[i]     = deb_q[i];
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            deb_q        <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    assign run_p  = press_q[0];
    assign step_p = press_q[1];

    // Divider: free-running in every state; cnt >= div (not ==) so a lowered div ticks at once.
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick;

    assign tick  = (cnt_q >= div);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cpu_clk_en is a bare strobe with no handshake: high for exactly one cycle, the
    // cycle after a tick seen in RUNNING (unless leaving RUNNING) or in STEP.
    state_e state_q;
    state_e state_d;
    logic   en_q;
    logic   en_d;

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        case (state_q)
            ST_HALTED: begin
                if (run_p && !cpu_hlt) begin
                    state_d = ST_RUNNING;
                end else if (step_p) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUNNING: begin
                if (run_p || cpu_hlt) begin
                    state_d = ST_HALTED;
                end else begin
                    en_d = tick;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    state_d = ST_HALTED;
                    en_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HALTED;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
        end
    end

    assign cpu_clk_en = en_q;
    assign running    = (state_q == ST_RUNNING);
    assign state_o    = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: expected strobe cycles are queued at stimulus time
// and a monitor pops one per observed cpu_clk_en pulse; state checks are made inline.
`timescale 1ns/1ps
module tb_clk_step_ctrl;

  localparam int DIV_W      = 16;
  localparam int DEB_W      = 16;
  localparam int DEB_CYCLES = 4;
`ifdef CLK_STEP_CTRL_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int PL     = 2 + DEB_CYCLES + 1;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int PL     = 2 + 1;
`endif
  // Raw buttons are raised just after edge 2; the state changes PL+1 edges later.
  localparam int R = 2;
  localparam int E = R + PL + 1;

  localparam logic [1:0] S_HALTED  = 2'b00;
  localparam logic [1:0] S_RUNNING = 2'b01;
  localparam logic [1:0] S_STEP    = 2'b10;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             btn_run  = 1'b0;
  logic             btn_step = 1'b0;
  logic             cpu_hlt  = 1'b0;
  logic [DIV_W-1:0] div      = '0;
  logic             cpu_clk_en;
  logic             running;
  logic [1:0]       state_o;

  int          checks   = 0;
  int          failures = 0;
  int          cyc;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  clk_step_ctrl #(
    .DIV_W      (DIV_W),
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .cpu_hlt    (cpu_hlt),
    .div        (div),
    .cpu_clk_en (cpu_clk_en),
    .running    (running),
    .state_o    (state_o)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Returns #1 after the falling edge at which cyc has reached c.
  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
    #1;
  endtask

  task automatic do_reset(input logic [DIV_W-1:0] d);
    chk("pending_strobes", exp_q.size(), 0);
    rst      = 1'b1;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    cpu_hlt  = 1'b0;
    div      = d;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_periodic(input int entry, input int period, input int last);
    for (int s = ((entry / period) + 1) * period; s <= last; s += period)
      exp_q.push_back(s);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cpu_clk_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected cyc=%0d actual=1 required=0", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_exp != cyc) begin
            failures++;
            $display("FAIL strobe_cycle actual=%0d required=%0d", cyc, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Run from reset with div=3: entry at cycle E, strobes every 4 cycles.
    do_reset(3);
    chk("rst_state", state_o, S_HALTED);
    chk("rst_running", running, 0);
    chk("rst_en", cpu_clk_en, 0);
    at_cyc(R);
    btn_run = 1'b1;
    push_periodic(E, 4, 40);
    at_cyc(E - 1);
    chk("run_not_yet", state_o, S_HALTED);
    at_cyc(E);
    chk("run_entry", state_o, S_RUNNING);
    chk("run_running", running, 1);
    at_cyc(12);
    btn_run = 1'b0;
    at_cyc(40);
    cpu_hlt = 1'b1;
    at_cyc(41);
    cpu_hlt = 1'b0;
    chk("hlt_stop", state_o, S_HALTED);
    chk("hlt_running", running, 0);
    at_cyc(60);
    chk("hlt_stays", state_o, S_HALTED);

    // Single step with div=5: one strobe at the first tick, then HALTED.
    do_reset(5);
    at_cyc(R);
    btn_step = 1'b1;
    exp_q.push_back(((E / 6) + 1) * 6);
    at_cyc(E);
    chk("step_entry", state_o, S_STEP);
    at_cyc(((E / 6) + 1) * 6);
    chk("step_done", state_o, S_HALTED);
    btn_step = 1'b0;
    at_cyc(((E / 6) + 1) * 6 + 50);
    chk("step_quiet", state_o, S_HALTED);

    // div=0: strobe every cycle; one-cycle HLT stops and eats that tick; run blocked by HLT.
    do_reset(0);
    at_cyc(R);
    btn_run = 1'b1;
    push_periodic(E, 1, 30);
    at_cyc(E);
    chk("div0_entry", state_o, S_RUNNING);
    at_cyc(12);
    btn_run = 1'b0;
    at_cyc(30);
    cpu_hlt = 1'b1;
    at_cyc(31);
    cpu_hlt = 1'b0;
    chk("div0_hlt_state", state_o, S_HALTED);
    chk("div0_hlt_no_strobe", cpu_clk_en, 0);
    at_cyc(38);
    cpu_hlt = 1'b1;
    at_cyc(40);
    btn_run = 1'b1;
    at_cyc(40 + PL + 1);
    chk("run_blocked_by_hlt", state_o, S_HALTED);
    at_cyc(52);
    btn_run = 1'b0;
    chk("run_blocked_later", state_o, S_HALTED);

    // Three-cycle glitch: rejected with debounce, accepted without it.
    do_reset(3);
    at_cyc(R);
    btn_run = 1'b1;
    at_cyc(R + 3);
    btn_run = 1'b0;
    if (!DEB_ON) push_periodic(E, 4, 20);
    at_cyc(20);
    chk("glitch_state", state_o, DEB_ON ? S_HALTED : S_RUNNING);

    // Run and step together, HLT low: run wins.
    do_reset(3);
    at_cyc(R);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    push_periodic(E, 4, 20);
    at_cyc(E);
    chk("both_run_wins", state_o, S_RUNNING);
    at_cyc(12);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    at_cyc(20);
    chk("both_still_running", state_o, S_RUNNING);

    // Run and step together, HLT high: step taken.
    do_reset(3);
    cpu_hlt = 1'b1;
    at_cyc(R);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    exp_q.push_back(((E / 4) + 1) * 4);
    at_cyc(E);
    chk("both_step_taken", state_o, S_STEP);
    at_cyc(((E / 4) + 1) * 4);
    chk("both_step_done", state_o, S_HALTED);
    btn_run  = 1'b0;
    btn_step = 1'b0;

    // div lowered from 200 to 10 at cnt=150: immediate tick, then every 11; async reset mid-run.
    do_reset(200);
    at_cyc(R);
    btn_run = 1'b1;
    at_cyc(E);
    chk("div_entry", state_o, S_RUNNING);
    at_cyc(12);
    btn_run = 1'b0;
    at_cyc(150);
    div = 10;
    exp_q.push_back(151);
    exp_q.push_back(162);
    exp_q.push_back(173);
    exp_q.push_back(184);
    at_cyc(184);
    chk("strobe_before_rst", cpu_clk_en, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_en", cpu_clk_en, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_state", state_o, S_HALTED);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    at_cyc(3);
    chk("post_rst_state", state_o, S_HALTED);
    chk("post_rst_en", cpu_clk_en, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- run-time bound ----------------
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
